// File: rtl/sif_id_stall_ctrl.sv
// sif_id_stall_ctrl
//   Consumer end of the load-use stall interface. Owns the IF/ID pipeline
//   register and produces PC write-enable and the ID/EX bubble request.
//   Sequences the post-branch flush window and runs a stall-length watchdog.
//
//   Optional: define SIF_ID_PERF_COUNTERS_EN to add the perf_stall_cycles and
//   perf_flush_count outputs. When it is undefined, those ports and their
//   logic are absent.
//
//   Cycle priority: rst > mem_busy > branch_taken > FLUSH > hazard stall > run.

module sif_id_stall_ctrl #(
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter int unsigned          FLUSH_DEPTH = 1,
   parameter int unsigned          MAX_STALL   = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_pipeline,
   input  logic                  mem_busy,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] if_pc,
   input  logic [DATA_WIDTH-1:0] if_instr,
   output logic                  pc_write_en,
   output logic                  ex_bubble,
   output logic [DATA_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic                  id_valid,
   output logic                  in_flush,
`ifdef SIF_ID_PERF_COUNTERS_EN
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flush_count,
`endif
   output logic                  stall_timeout
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // IF/ID register update selection
   typedef enum logic [1:0] {
      IFID_HOLD  = 2'd0,
      IFID_LOAD  = 2'd1,
      IFID_FLUSH = 2'd2
   } ifid_op_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);
   localparam logic [7:0] STALL_MAX  = 8'(MAX_STALL);

   state_t     state;
   state_t     state_next;
   logic [2:0] flush_cnt;
   logic [2:0] flush_cnt_next;
   logic [7:0] stall_cnt;
   logic [7:0] stall_cnt_next;
   logic       timeout_next;
   ifid_op_t   ifid_op;
   logic       hazard_stall;
   logic       branch_accept;
   logic [8:0] stall_inc;

   assign stall_inc = {1'b0, stall_cnt} + 9'd1;
   assign in_flush  = (state == FLUSH);

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         flush_cnt     <= '0;
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         state         <= state_next;
         flush_cnt     <= flush_cnt_next;
         stall_cnt     <= stall_cnt_next;
         stall_timeout <= timeout_next;
      end
   end

   // Next-state, counter and control-output decode in priority order
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      stall_cnt_next = stall_cnt;
      timeout_next   = stall_timeout;
      ifid_op        = IFID_HOLD;
      pc_write_en    = 1'b0;
      ex_bubble      = 1'b0;
      hazard_stall   = 1'b0;
      branch_accept  = 1'b0;

      if (rst) begin
         pc_write_en = 1'b0;
         ex_bubble   = 1'b1;
      end else if (mem_busy) begin
         // whole pipe frozen; EX re-presents any branch afterwards
         pc_write_en = 1'b0;
         ex_bubble   = 1'b0;
      end else if (branch_taken) begin
         pc_write_en    = 1'b1;
         ex_bubble      = 1'b1;
         ifid_op        = IFID_FLUSH;
         stall_cnt_next = '0;
         branch_accept  = 1'b1;
         if (FLUSH_INIT != 3'd0) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_INIT;
         end else begin
            state_next     = RUN;
            flush_cnt_next = '0;
         end
      end else if (state == FLUSH) begin
         pc_write_en    = 1'b1;
         ex_bubble      = 1'b0;
         ifid_op        = IFID_FLUSH;
         stall_cnt_next = '0;
         flush_cnt_next = flush_cnt - 3'd1;
         if (flush_cnt == 3'd1) begin
            state_next = RUN;
         end
      end else if (stall_pipeline && id_valid) begin
         pc_write_en  = 1'b0;
         ex_bubble    = 1'b1;
         hazard_stall = 1'b1;
         if (stall_cnt != STALL_MAX) begin
            stall_cnt_next = stall_inc[7:0];
         end
         if (stall_inc == {1'b0, STALL_MAX}) begin
            timeout_next = 1'b1;
         end
      end else begin
         pc_write_en    = 1'b1;
         ex_bubble      = 1'b0;
         ifid_op        = IFID_LOAD;
         stall_cnt_next = '0;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         id_pc    <= '0;
         id_instr <= NOP_INSTR;
         id_valid <= 1'b0;
      end else begin
         case (ifid_op)
            IFID_LOAD: begin
               id_pc    <= if_pc;
               id_instr <= if_instr;
               id_valid <= 1'b1;
            end
            IFID_FLUSH: begin
               id_pc    <= if_pc;
               id_instr <= NOP_INSTR;
               id_valid <= 1'b0;
            end
            default: begin
               id_pc    <= id_pc;
               id_instr <= id_instr;
               id_valid <= id_valid;
            end
         endcase
      end
   end

`ifdef SIF_ID_PERF_COUNTERS_EN
   // Performance counters: hazard-stall cycles and accepted branches
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (hazard_stall) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (branch_accept) begin
            perf_flush_count <= perf_flush_count + 32'd1;
         end
      end
   end
`else
   logic perf_unused;
   assign perf_unused = hazard_stall ^ branch_accept;
`endif

endmodule

// File: tb/tb_sif_id_stall_ctrl.sv
// Directed testbench for sif_id_stall_ctrl (FLUSH_DEPTH=1, MAX_STALL=4).
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, registered outputs 1ns after the rising edge.

module tb_sif_id_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_pipeline;
   logic        mem_busy;
   logic        branch_taken;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        pc_write_en;
   logic        ex_bubble;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        in_flush;
   logic        stall_timeout;
`ifdef SIF_ID_PERF_COUNTERS_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   sif_id_stall_ctrl #(
      .DATA_WIDTH (32),
      .FLUSH_DEPTH(1),
      .MAX_STALL  (4),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_pipeline(stall_pipeline),
      .mem_busy      (mem_busy),
      .branch_taken  (branch_taken),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .pc_write_en   (pc_write_en),
      .ex_bubble     (ex_bubble),
      .id_pc         (id_pc),
      .id_instr      (id_instr),
      .id_valid      (id_valid),
      .in_flush      (in_flush),
`ifdef SIF_ID_PERF_COUNTERS_EN
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_count (perf_flush_count),
`endif
      .stall_timeout (stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // apply inputs on the falling edge, then settle
   task automatic drive(input logic r, input logic st, input logic mb, input logic br,
                        input logic [31:0] pc, input logic [31:0] ins);
      @(negedge clk);
      rst            = r;
      stall_pipeline = st;
      mem_busy       = mb;
      branch_taken   = br;
      if_pc          = pc;
      if_instr       = ins;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctrl(input string tag, input logic pwe, input logic bub);
      chk({tag, "_pc_we"}, {31'b0, pc_write_en}, {31'b0, pwe});
      chk({tag, "_bubble"}, {31'b0, ex_bubble}, {31'b0, bub});
   endtask

   task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v);
      chk({tag, "_id_pc"}, id_pc, pc);
      chk({tag, "_id_instr"}, id_instr, ins);
      chk({tag, "_id_valid"}, {31'b0, id_valid}, {31'b0, v});
   endtask

   initial begin
      // reset: two cycles
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      chk_ctrl("rst", 0, 1);
      tick();
      drive(1, 1, 1, 1, 32'h0, 32'h0);
      chk_ctrl("rst_prio", 0, 1);
      tick();
      chk_id("rst", 32'h0, NOP, 0);
      chk("rst_flush", {31'b0, in_flush}, 32'h0);
      chk("rst_timeout", {31'b0, stall_timeout}, 32'h0);

      // stream of fetches
      drive(0, 0, 0, 0, 32'h0, 32'h00A0_0093);
      chk_ctrl("run0", 1, 0);
      tick();
      chk_id("run0", 32'h0, 32'h00A0_0093, 1);
      drive(0, 0, 0, 0, 32'h4, 32'h0010_8113);
      chk_ctrl("run1", 1, 0);
      tick();
      chk_id("run1", 32'h4, 32'h0010_8113, 1);
      drive(0, 0, 0, 0, 32'h8, 32'h0020_8133);
      tick();
      chk_id("run2", 32'h8, 32'h0020_8133, 1);

      // single load-use stall
      drive(0, 1, 0, 0, 32'hC, 32'h0031_0193);
      chk_ctrl("stall", 0, 1);
      tick();
      chk_id("stall", 32'h8, 32'h0020_8133, 1);
      drive(0, 0, 0, 0, 32'hC, 32'h0031_0193);
      chk_ctrl("resume", 1, 0);
      tick();
      chk_id("resume", 32'hC, 32'h0031_0193, 1);

      // taken branch, FLUSH_DEPTH=1
      drive(0, 0, 0, 1, 32'h10, 32'h1111_1111);
      chk_ctrl("br", 1, 1);
      tick();
      chk_id("br", 32'h10, NOP, 0);
      chk("br_flush", {31'b0, in_flush}, 32'h1);
      drive(0, 0, 0, 0, 32'h40, 32'h2222_2222);
      chk_ctrl("flush", 1, 0);
      tick();
      chk_id("flush", 32'h40, NOP, 0);
      chk("flush_done", {31'b0, in_flush}, 32'h0);
      drive(0, 0, 0, 0, 32'h44, 32'h0050_0213);
      tick();
      chk_id("target", 32'h44, 32'h0050_0213, 1);

      // stall and branch together: branch wins
      drive(0, 1, 0, 1, 32'h48, 32'h3333_3333);
      chk_ctrl("st_br", 1, 1);
      tick();
      chk_id("st_br", 32'h48, NOP, 0);
      chk("st_br_flush", {31'b0, in_flush}, 32'h1);
      drive(0, 1, 0, 0, 32'h80, 32'h4444_4444);
      chk_ctrl("flush_ign_st", 1, 0);
      tick();
      chk("flush_ign_st_run", {31'b0, in_flush}, 32'h0);
      // stall with id_valid=0 is not a stall
      drive(0, 1, 0, 0, 32'h84, 32'h0060_0293);
      chk_ctrl("st_invalid", 1, 0);
      tick();
      chk_id("st_invalid", 32'h84, 32'h0060_0293, 1);

      // stall, then mem_busy x3 with stall+branch asserted, then branch
      drive(0, 1, 0, 0, 32'h88, 32'h5555_5555);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 1, 32'h90, 32'h6666_6666);
         chk_ctrl("busy", 0, 0);
         tick();
         chk_id("busy", 32'h84, 32'h0060_0293, 1);
         chk("busy_flush", {31'b0, in_flush}, 32'h0);
      end
      drive(0, 0, 0, 1, 32'h8C, 32'h7777_7777);
      chk_ctrl("busy_br", 1, 1);
      tick();
      chk_id("busy_br", 32'h8C, NOP, 0);
      chk("busy_br_flush", {31'b0, in_flush}, 32'h1);
      drive(0, 0, 0, 0, 32'hC0, 32'h8888_8888);
      tick();
      drive(0, 0, 0, 0, 32'hC4, 32'h0070_0313);
      tick();
      chk_id("post_br", 32'hC4, 32'h0070_0313, 1);
      chk("post_br_to", {31'b0, stall_timeout}, 32'h0);

      // 3-cycle stall leaves watchdog clear
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 32'hC8, 32'h9999_9999);
         tick();
      end
      chk("stall3_to", {31'b0, stall_timeout}, 32'h0);
      drive(0, 0, 0, 0, 32'hC8, 32'h0080_0393);
      tick();
      chk("release3_to", {31'b0, stall_timeout}, 32'h0);

      // stall 2, mem_busy 3 (count frozen), stall 1 -> still clear, 1 more -> trip
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0, 32'hCC, 32'hAAAA_AAAA);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 32'hCC, 32'hAAAA_AAAA);
         tick();
      end
      drive(0, 1, 0, 0, 32'hCC, 32'hAAAA_AAAA);
      tick();
      chk("frozen_cnt3_to", {31'b0, stall_timeout}, 32'h0);
      drive(0, 1, 0, 0, 32'hCC, 32'hAAAA_AAAA);
      tick();
      chk("frozen_cnt4_to", {31'b0, stall_timeout}, 32'h1);
      chk_id("long_stall", 32'hC8, 32'h0080_0393, 1);
      drive(0, 0, 0, 0, 32'hCC, 32'h0090_0413);
      tick();
      chk("sticky_to", {31'b0, stall_timeout}, 32'h1);

      // reset clears watchdog; contiguous 4-cycle stall trips on 4th edge
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      tick();
      chk("rst2_to", {31'b0, stall_timeout}, 32'h0);
      drive(0, 0, 0, 0, 32'h100, 32'h00A0_0493);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 32'h104, 32'hBBBB_BBBB);
         tick();
      end
      chk("stall4_e3_to", {31'b0, stall_timeout}, 32'h0);
      drive(0, 1, 0, 0, 32'h104, 32'hBBBB_BBBB);
      tick();
      chk("stall4_e4_to", {31'b0, stall_timeout}, 32'h1);
      drive(0, 1, 0, 0, 32'h104, 32'hBBBB_BBBB);
      chk_ctrl("sat_stall", 0, 1);
      tick();
      chk("sat_to", {31'b0, stall_timeout}, 32'h1);

      // reset mid-flush aborts the flush
      drive(0, 0, 0, 1, 32'h108, 32'hCCCC_CCCC);
      tick();
      chk("pre_abort_flush", {31'b0, in_flush}, 32'h1);
      drive(1, 0, 0, 0, 32'h200, 32'hDDDD_DDDD);
      tick();
      chk("abort_flush", {31'b0, in_flush}, 32'h0);
      chk_id("abort", 32'h0, NOP, 0);
      drive(0, 0, 0, 0, 32'h200, 32'h00B0_0513);
      tick();
      chk_id("after_abort", 32'h200, 32'h00B0_0513, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
